// File: rtl/vga_text_ctrl.sv
// 80x25 text-mode VGA controller: WRITE/ACK cell-write port, dual-port cell buffer,
// 640x480@60 scan-out through an external 8x16 font ROM. Optional cursor: VGA_CURSOR_EN.
`ifndef VGA_WRITE_PIN
`define VGA_WRITE_PIN 0
`endif
`ifndef VGA_ACK
`define VGA_ACK 0
`endif

module vga_text_ctrl #(
    parameter int unsigned COLS   = 80,
    parameter int unsigned ROWS   = 25,
    parameter int unsigned H_VIS  = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_VIS  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] vga_ctrl,
    output logic [31:0] vga_stat,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue
);

    localparam int unsigned NCELL = COLS * ROWS;
    localparam int unsigned AW    = $clog2(NCELL);

    localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT  = 10'(H_VIS);
    localparam logic [9:0] V_ACT  = 10'(V_VIS);
    localparam logic [9:0] H_SS   = 10'(H_VIS + H_FP);
    localparam logic [9:0] H_SE   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] V_SS   = 10'(V_VIS + V_FP);
    localparam logic [9:0] V_SE   = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0] V_TXT  = 10'(ROWS * 16);

    // ---------------- handshake FSM ----------------
    typedef enum logic {
        S_IDLE,
        S_ACK
    } hs_state_e;

    hs_state_e state_q, state_d;
    logic      wr_req;
    logic      addr_ok;
    logic      wr_en;

    assign wr_req  = vga_ctrl[`VGA_WRITE_PIN];
    assign addr_ok = addr < 32'(NCELL);

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wr_req) begin
                    wr_en   = addr_ok & ~rst;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (!wr_req) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        vga_stat                = '0;
        vga_stat[`VGA_ACK]      = (state_q == S_ACK);
    end

    // ---------------- counters ----------------
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       h_wrap;

    assign h_wrap = (h_cnt_q == H_LAST);

    always_comb begin
        h_cnt_d = h_wrap ? '0 : h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // ---------------- S0: buffer read address ----------------
    logic [11:0] rd_addr;
    logic        rd_ok;
    logic        de0, hs0, vs0;

    assign rd_addr = 12'(v_cnt_q[8:4]) * 12'(COLS) + 12'(h_cnt_q[9:3]);
    assign rd_ok   = rd_addr < 12'(NCELL);
    assign de0     = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT) && (v_cnt_q < V_TXT);
    assign hs0     = !((h_cnt_q >= H_SS) && (h_cnt_q < H_SE));
    assign vs0     = !((v_cnt_q >= V_SS) && (v_cnt_q < V_SE));

    // Write and scan ports share the clock; the read sees the pre-write value.
    logic [15:0] buf_mem [NCELL];
    logic [15:0] cell_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_mem[addr[AW-1:0]] <= data[15:0];
        end
        cell_q <= rd_ok ? buf_mem[rd_addr[AW-1:0]] : '0;
    end

    // ---------------- S1 / S2 pipeline ----------------
    logic [3:0] gr_q1;
    logic [2:0] x_q1, x_q2;
    logic       de_q1, de_q2;
    logic       hs_q1, hs_q2, vs_q1, vs_q2;
    logic [7:0] attr_q2;
    logic [3:0] red_q, green_q, blue_q;
    logic       hsync_q, vsync_q;

    assign font_addr = {cell_q[7:0], gr_q1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gr_q1   <= '0;
            x_q1    <= '0;
            x_q2    <= '0;
            de_q1   <= 1'b0;
            de_q2   <= 1'b0;
            hs_q1   <= 1'b1;
            hs_q2   <= 1'b1;
            vs_q1   <= 1'b1;
            vs_q2   <= 1'b1;
            attr_q2 <= '0;
        end else begin
            gr_q1   <= v_cnt_q[3:0];
            x_q1    <= h_cnt_q[2:0];
            de_q1   <= de0;
            hs_q1   <= hs0;
            vs_q1   <= vs0;
            x_q2    <= x_q1;
            de_q2   <= de_q1;
            hs_q2   <= hs_q1;
            vs_q2   <= vs_q1;
            attr_q2 <= cell_q[15:8];
        end
    end

    logic pixel;

`ifdef VGA_CURSOR_EN
    logic [AW-1:0] cursor_q;
    logic [5:0]    frame_q;
    logic          cur0, cur_q1, cur_q2;

    // Cursor covers glyph rows 14-15 of the cursor cell during the "on" half of the blink.
    assign cur0 = frame_q[5] && rd_ok && (rd_addr == 12'(cursor_q)) && (v_cnt_q[3:1] == 3'b111);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cursor_q <= '0;
            frame_q  <= '0;
            cur_q1   <= 1'b0;
            cur_q2   <= 1'b0;
        end else begin
            if (wr_en) begin
                cursor_q <= addr[AW-1:0];
            end
            if (h_wrap && (v_cnt_q == V_SS - 10'd1)) begin
                frame_q <= frame_q + 6'd1;
            end
            cur_q1 <= cur0;
            cur_q2 <= cur_q1;
        end
    end

    assign pixel = font_data[3'd7 - x_q2] | cur_q2;
`else
    assign pixel = font_data[3'd7 - x_q2];
`endif

    // ---------------- S3: colour ----------------
    function automatic logic [3:0] chan(input logic on, input logic inten);
        if (on) begin
            return inten ? 4'hF : 4'hA;
        end
        return inten ? 4'h5 : 4'h0;
    endfunction

    logic [3:0] cidx;
    assign cidx = pixel ? attr_q2[3:0] : attr_q2[7:4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            red_q   <= de_q2 ? chan(cidx[2], cidx[3]) : '0;
            green_q <= de_q2 ? chan(cidx[1], cidx[3]) : '0;
            blue_q  <= de_q2 ? chan(cidx[0], cidx[3]) : '0;
            hsync_q <= hs_q2;
            vsync_q <= vs_q2;
        end
    end

    assign red   = red_q;
    assign green = green_q;
    assign blue  = blue_q;
    assign hsync = hsync_q;
    assign vsync = vsync_q;

    logic unused_bits;
    assign unused_bits = ^{vga_ctrl, data[31:16]};

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Directed bench for vga_text_ctrl with shortened horizontal timing (80-clk lines).
`ifndef VGA_WRITE_PIN
`define VGA_WRITE_PIN 0
`endif
`ifndef VGA_ACK
`define VGA_ACK 0
`endif

module tb_vga_text_ctrl;

    localparam int H_TOT = 80;
    localparam int V_TOT = 525;
    localparam int FRAME = H_TOT * V_TOT;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] vga_ctrl = '0;
    logic [31:0] vga_stat;
    logic [31:0] addr = '0;
    logic [31:0] data = '0;
    logic [11:0] font_addr;
    logic [7:0]  font_data = '0;
    logic        hsync, vsync;
    logic [3:0]  red, green, blue;

    int n_cmp = 0;
    int n_bad = 0;

    vga_text_ctrl #(
        .COLS(80), .ROWS(25),
        .H_VIS(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_VIS(480), .V_FP(10), .V_SYNC(2), .V_BP(33)
    ) dut (
        .clk(clk), .rst(rst),
        .vga_ctrl(vga_ctrl), .vga_stat(vga_stat),
        .addr(addr), .data(data),
        .font_addr(font_addr), .font_data(font_data),
        .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue)
    );

    always #20 clk = ~clk;

    // Font ROM: char 0x41 has a single pixel walking right on glyph rows 0..7.
    always @(posedge clk) begin
        if (font_addr[11:4] == 8'h41 && font_addr[3:0] < 4'd8)
            font_data <= 8'h80 >> font_addr[2:0];
        else
            font_data <= 8'h00;
    end

    // Reference raster position, delayed 3 clocks to line up with the pins.
    logic [9:0]  mh, mv;
    logic [19:0] p1, p2, p3;
    logic        v1, v2, v3;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mh <= '0; mv <= '0;
            p1 <= '0; p2 <= '0; p3 <= '0;
            v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
        end else begin
            p1 <= {mv, mh}; v1 <= 1'b1;
            p2 <= p1;       v2 <= v1;
            p3 <= p2;       v3 <= v2;
            if (mh == 10'(H_TOT - 1)) begin
                mh <= '0;
                mv <= (mv == 10'(V_TOT - 1)) ? '0 : mv + 10'd1;
            end else begin
                mh <= mh + 10'd1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        wr;
        logic [31:0] a;
        logic [15:0] d;
        logic        ack;
    } hs_vec_t;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pix_t;

    function automatic hs_vec_t mk(input logic wr, input int a, input logic [15:0] d, input logic ack);
        hs_vec_t t;
        t.wr = wr; t.a = 32'(a); t.d = d; t.ack = ack;
        return t;
    endfunction

    function automatic pix_t mp(input int h, input int v, input logic [3:0] r,
                                input logic [3:0] g, input logic [3:0] b);
        pix_t t;
        t.h = 10'(h); t.v = 10'(v); t.r = r; t.g = g; t.b = b;
        return t;
    endfunction

    hs_vec_t hv[$];
    pix_t    pv[$];
    bit      seen[16];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_stat;
        logic [9:0]  ph, pvv;
        logic        e_hs, e_vs, blank;
        int          sync_err, blank_err, hs_low, vs_low;

        // Handshake vectors: {WRITE, addr, data, expected ACK after the next edge}
        hv.push_back(mk(1, 5,    16'h0241, 1));
        hv.push_back(mk(0, 5,    16'h0241, 0));
        for (int i = 0; i < 5; i++) hv.push_back(mk(1, 5, 16'h0241, 1));
        for (int i = 0; i < 5; i++) hv.push_back(mk(1, 5, 16'h0242, 1));
        hv.push_back(mk(0, 5,    16'h0242, 0));
        hv.push_back(mk(1, 0,    16'h0241, 1));
        hv.push_back(mk(0, 0,    16'h0241, 0));
        hv.push_back(mk(1, 2000, 16'h0733, 1));
        hv.push_back(mk(0, 2000, 16'h0733, 0));
        hv.push_back(mk(1, 2048, 16'h0733, 1));
        hv.push_back(mk(0, 2048, 16'h0733, 0));
        hv.push_back(mk(1, 2053, 16'h0733, 1));
        hv.push_back(mk(0, 2053, 16'h0733, 0));
        hv.push_back(mk(1, 1,    16'h0E41, 1));
        hv.push_back(mk(0, 1,    16'h0E41, 0));
        hv.push_back(mk(1, 80,   16'h1C41, 1));
        hv.push_back(mk(0, 80,   16'h1C41, 0));
        hv.push_back(mk(1, 8,    16'hF000, 1));
        hv.push_back(mk(0, 8,    16'hF000, 0));

        // Expected pixels {h, v, r, g, b}
        pv.push_back(mp(0,  0,  4'h0, 4'hA, 4'h0));
        pv.push_back(mp(1,  0,  4'h0, 4'h0, 4'h0));
        pv.push_back(mp(40, 0,  4'h0, 4'hA, 4'h0));
        pv.push_back(mp(41, 0,  4'h0, 4'h0, 4'h0));
        pv.push_back(mp(48, 0,  4'h0, 4'hA, 4'h0));
        pv.push_back(mp(8,  3,  4'h0, 4'h0, 4'h0));
        pv.push_back(mp(11, 3,  4'hF, 4'hF, 4'h5));
        pv.push_back(mp(0,  16, 4'hF, 4'h5, 4'h5));
        pv.push_back(mp(1,  16, 4'h0, 4'h0, 4'hA));

        // Reset state
        #5 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_stat",  vga_stat, 32'h0);
        chk("reset_hsync", 32'(hsync), 32'h1);
        chk("reset_vsync", 32'(vsync), 32'h1);
        chk("reset_rgb",   32'({red, green, blue}), 32'h0);
        rst = 1'b0;

        // Handshake table
        for (int i = 0; i < hv.size(); i++) begin
            vga_ctrl                 = '0;
            vga_ctrl[`VGA_WRITE_PIN] = hv[i].wr;
            addr                     = hv[i].a;
            data                     = {16'h0, hv[i].d};
            @(negedge clk);
            exp_stat           = '0;
            exp_stat[`VGA_ACK] = hv[i].ack;
            chk($sformatf("hs_vec[%0d]", i), vga_stat, exp_stat);
        end

        // Reset in the middle of a handshake; the write to cell 6 completed before it
        vga_ctrl                 = '0;
        vga_ctrl[`VGA_WRITE_PIN] = 1'b1;
        addr                     = 32'd6;
        data                     = 32'h0241;
        @(negedge clk);
        exp_stat           = '0;
        exp_stat[`VGA_ACK] = 1'b1;
        chk("midrst_ack_before", vga_stat, exp_stat);
        rst = 1'b1;
        #1;
        chk("midrst_stat",  vga_stat, 32'h0);
        chk("midrst_hsync", 32'(hsync), 32'h1);
        chk("midrst_vsync", 32'(vsync), 32'h1);
        chk("midrst_rgb",   32'({red, green, blue}), 32'h0);
        chk("midrst_hcnt",  32'(dut.h_cnt_q), 32'h0);
        chk("midrst_vcnt",  32'(dut.v_cnt_q), 32'h0);
        vga_ctrl = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // One full frame from the counters' reset: sync, blanking, and pixel checks
        sync_err = 0; blank_err = 0; hs_low = 0; vs_low = 0;
        for (int i = 0; i < FRAME; i++) begin
            ph  = p3[9:0];
            pvv = p3[19:10];
            if (!v3) begin
                e_hs = 1'b1; e_vs = 1'b1; blank = 1'b1;
            end else begin
                e_hs  = !(ph >= 10'd68 && ph < 10'd76);
                e_vs  = !(pvv >= 10'd490 && pvv < 10'd492);
                blank = !(ph < 10'd64 && pvv < 10'd400);
            end
            if (hsync !== e_hs || vsync !== e_vs) sync_err++;
            if (hsync === 1'b0) hs_low++;
            if (vsync === 1'b0) vs_low++;
            if (blank && {red, green, blue} !== 12'h0) blank_err++;
            if (v3) begin
                for (int k = 0; k < pv.size(); k++) begin
                    if (pv[k].h == ph && pv[k].v == pvv) begin
                        seen[k] = 1'b1;
                        chk($sformatf("pixel(%0d,%0d)", ph, pvv), 32'({red, green, blue}),
                            32'({pv[k].r, pv[k].g, pv[k].b}));
                    end
                end
            end
            @(negedge clk);
        end

        chk("sync_timing_errors", 32'(sync_err), 32'd0);
        chk("blank_rgb_errors",   32'(blank_err), 32'd0);
        chk("hsync_low_clocks",   32'(hs_low), 32'(8 * V_TOT));
        chk("vsync_low_clocks",   32'(vs_low), 32'(2 * H_TOT));
        for (int k = 0; k < pv.size(); k++)
            chk($sformatf("pixel_reached[%0d]", k), 32'(seen[k]), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_text_ctrl.md
Name: vga_text_ctrl

Overview:
- Text-mode VGA device on the mobo's VGA ctrl/stat port; downstream of the mobo sequencer.
- Accepts one cell write per WRITE/ACK handshake into an 80x25 character buffer.
- Scans the buffer out as 640x480@60 video through an external 8x16 font ROM.
- clk is the 25 MHz pixel clock.

Parameters:
- COLS, 80, text columns
- ROWS, 25, text rows; scanlines below ROWS*16 render background black
- H_VIS/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels
- V_VIS/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset
- vga_ctrl  in  32  bit `VGA_WRITE_PIN = write request; other bits ignored
- vga_stat  out  32  bit `VGA_ACK = write acknowledge; all other bits 0
- addr  in  32  cell index, row*COLS+col
- data  in  32  [7:0] char code, [15:8] attribute ([3:0] fg, [7:4] bg); [31:16] ignored
- font_addr  out  12  {char[7:0], glyph_row[3:0]}
- font_data  in  8  glyph row; bit 7 = leftmost pixel; valid 1 clk after font_addr
- hsync  out  1  active low
- vsync  out  1  active low
- red, green, blue  out  4 each  pixel colour

Behaviour:
- Reset: rst, asynchronous, active-high; clock clk. On reset: vga_stat=0, hsync=1, vsync=1, rgb=0, h/v counters=0, handshake FSM=IDLE. Buffer contents are not reset and persist across rst.
- Handshake FSM, IDLE:
  - On posedge with vga_ctrl[`VGA_WRITE_PIN]=1, latch addr and data.
  - If addr < COLS*ROWS, write 16-bit cell {data[15:8],data[7:0]} to buffer[addr]; out-of-range addresses are dropped silently.
  - Next cycle vga_stat[`VGA_ACK]=1; go to ACK.
- Handshake FSM, ACK: hold ACK while WRITE=1. When WRITE=0, ACK drops next cycle and the FSM returns to IDLE.
- Exactly one buffer write per handshake. A WRITE held high does not re-write.
- Minimum cycle: WRITE→ACK 1 clk; WRITE low→ACK low 1 clk.
- Buffer is dual-port: write port on handshake, read port on scan. A same-cycle read of the address being written returns the old value.
- Counters: h_cnt 0..H_TOTAL-1 (800), wraps to 0 and increments v_cnt; v_cnt 0..V_TOTAL-1 (525), wraps to 0.
- Sync timing:
  - hsync low when H_VIS+H_FP ≤ h_cnt < H_VIS+H_FP+H_SYNC.
  - vsync likewise on v_cnt.
  - de = h_cnt<H_VIS && v_cnt<V_VIS.
- Pixel pipeline, latency 3 clk from counters to pins:
  - S0: col=h_cnt[9:3], row=v_cnt[8:4], buffer read addr = row*COLS+col.
  - S1: cell available; font_addr={char, v_cnt[3:0]} (delayed).
  - S2: font_data available; pixel = font_data[7-x[2:0]] with x delayed 2 clk.
  - S3: registered rgb.
  - hsync, vsync and de are delayed 3 clk to align with rgb.
- Colour rules:
  - Colour index = pixel ? attr[3:0] : attr[7:4].
  - Index bits: [0]=B, [1]=G, [2]=R, [3]=intensity.
  - Channel = bit ? (I ? F : A) : (I ? 5 : 0).
  - rgb=0 when de=0 or row ≥ ROWS.
- rst mid-handshake: ACK drops immediately. A pending latched write is either completed or not, but never half-written.

Optional Feature:
- VGA_CURSOR_EN defined:
  - Cursor register holds the addr of the last in-range write; reset 0.
  - 6-bit frame counter increments at each vsync start.
  - On the cursor cell, glyph rows 14–15 are forced to all-ones (fg colour) while frame_cnt[5]=1, i.e. a 32-frame on / 32-frame off blink.
- Undefined: no cursor logic; the glyph is rendered unmodified.

Test Plan:
- Single write: WRITE=1, addr=5, data=0x0241 → buffer[5]=0x0241, ACK=1 next clk. WRITE=0 → ACK=0 next clk, FSM IDLE.
- Held WRITE: keep WRITE=1 for 10 clk, change data to 0x0242 mid-way → buffer[5] stays 0x0241 and ACK stays 1 throughout.
- Out of range: addr=2000, data=0x0733 → ACK handshake completes normally; no buffer entry changes (check cells 0 and 1999 unchanged).
- Timing: free-run 2 frames → hsync low exactly 96 clk per 800-clk line, vsync low exactly 2 lines per 525-line frame, rgb=0 outside the 640x480 active area.
- Pixel: cell 0 = 0x0241, font ROM returns 0x80 for char 0x41 row 0 → pixel (0,0) rgb=(0,A,0), pixel (1,0) rgb=(0,0,0), 3 clk after counters at (0,0).
- Reset mid-handshake: assert rst while ACK=1 → vga_stat=0, hsync=vsync=1, counters=0 immediately; buffer contents retained after reset release.
